// File: rtl/arb_pkg.sv
// ============================================================================
// arb_pkg: shared constants, FSM encoding and helpers for apb_req_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int DEFAULT_AW = 8;
  localparam int DEFAULT_DW = 8;
  localparam int MAX_REQ    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SETUP  = 3'b010,
    ST_ACCESS = 3'b100
  } state_t;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    idx_to_onehot = MAX_REQ'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_rr_pick.sv
// ============================================================================
// arb_rr_pick: combinational round-robin picker, searching upward from
// last_grant+1 with wrap.  Revision: 1.0
// ============================================================================
`default_nettype none

module arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  int          cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    winner   = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_grant) + i) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!valid && req[cand_idx]) begin
        valid  = 1'b1;
        winner = cand_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_req_arbiter.sv
// ============================================================================
// apb_req_arbiter: round-robin sharing of one APB-style register port among
// NUM_REQ requesters. Optional ACCESS timeout: ARB_TIMEOUT_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module apb_req_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int AW             = DEFAULT_AW,
  parameter int DW             = DEFAULT_DW,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  pclk_i,
  input  logic                  prst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*AW-1:0] req_addr_i,
  input  logic [NUM_REQ*DW-1:0] req_wdata_i,
  input  logic [NUM_REQ-1:0]    req_write_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [DW-1:0]         rdata_o,
  output logic                  err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [AW-1:0]         paddr_o,
  output logic [DW-1:0]         pwdata_o,
  input  logic                  pready_i,
  input  logic [DW-1:0]         prdata_i,
  input  logic                  perror_i
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_req_arbiter: unsupported parameter set");
  end

  state_t        state;
  logic [IW-1:0] cur;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] win;
  logic          win_valid;

  arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req        (req_i),
    .last_grant (last_grant),
    .winner     (win),
    .valid      (win_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;
`endif

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state      <= ST_IDLE;
      cur        <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      gnt_o      <= '0;
      done_o     <= '0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
      psel_o     <= 1'b0;
      penable_o  <= 1'b0;
      pwrite_o   <= 1'b0;
      paddr_o    <= '0;
      pwdata_o   <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      done_o  <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      case (state)
        // The done cycle is held in IDLE without granting: one idle gap.
        ST_IDLE: begin
          if (win_valid && !(|done_o)) begin
            cur       <= win;
            paddr_o   <= req_addr_i[win*AW +: AW];
            pwdata_o  <= req_wdata_i[win*DW +: DW];
            pwrite_o  <= req_write_i[win];
            gnt_o     <= NUM_REQ'(idx_to_onehot(3'(win)));
            psel_o    <= 1'b1;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_o <= 1'b1;
          state     <= ST_ACCESS;
`ifdef ARB_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end
        ST_ACCESS: begin
          if (pready_i) begin
            psel_o     <= 1'b0;
            penable_o  <= 1'b0;
            gnt_o      <= '0;
            done_o     <= gnt_o;
            rdata_o    <= pwrite_o ? '0 : prdata_i;
            err_o      <= perror_i;
            last_grant <= cur;
            state      <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt == LAST_WAIT) begin
            psel_o     <= 1'b0;
            penable_o  <= 1'b0;
            gnt_o      <= '0;
            done_o     <= gnt_o;
            rdata_o    <= '0;
            err_o      <= 1'b1;
            last_grant <= cur;
            state      <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
// ============================================================================
// tb_apb_req_arbiter: scoreboard bench for apb_req_arbiter with a small
// memory-backed slave. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            pclk = 1'b0;
  logic            prst = 1'b1;
  logic [N-1:0]    req_i = '0;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_wdata_i = '0;
  logic [N-1:0]    req_write_i = '0;
  logic [N-1:0]    gnt_o, done_o;
  logic [DW-1:0]   rdata_o, pwdata_o, prdata_i;
  logic            err_o, psel_o, penable_o, pwrite_o, perror_i;
  logic [AW-1:0]   paddr_o;
  logic            pready_i = 1'b1;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(15)) dut (
    .pclk_i(pclk), .prst_i(prst), .req_i(req_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_write_i(req_write_i), .gnt_o(gnt_o),
    .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pready_i(pready_i), .prdata_i(prdata_i),
    .perror_i(perror_i)
  );

  // Slave: unwritten locations read back as addr ^ 0x5A; 0x20 errors.
  logic [7:0]   mem [256];
  logic [255:0] mem_ok;
  always @(posedge pclk or posedge prst) begin
    if (prst) mem_ok <= '0;
    else if (psel_o && penable_o && pready_i && pwrite_o) begin
      mem[paddr_o]    <= pwdata_o;
      mem_ok[paddr_o] <= 1'b1;
    end
  end
  assign prdata_i = mem_ok[paddr_o] ? mem[paddr_o] : (paddr_o ^ 8'h5A);
  assign perror_i = (paddr_o == 8'h20);

  typedef struct packed { logic [1:0] id; logic [7:0] rdata; logic err; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  task automatic drive_req(input int r, input logic [7:0] a, input logic [7:0] d, input logic w);
    req_addr_i[r*AW +: AW] = a;
    req_wdata_i[r*DW +: DW] = d;
    req_write_i[r] = w;
    req_i[r] = 1'b1;
  endtask

  task automatic wait_done(input int budget, output logic [3:0] d, output logic [7:0] rd,
                           output logic er, output int cyc);
    d = '0; rd = '0; er = 1'b0; cyc = 0;
    while (cyc < budget) begin
      @(negedge pclk);
      cyc++;
      if (done_o != 0) begin
        d = done_o; rd = rdata_o; er = err_o;
        break;
      end
    end
  endtask

  task automatic test_reset;
    prst = 1'b1;
    repeat (2) @(negedge pclk);
    checks++;
    if ({gnt_o, done_o, rdata_o, err_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== '0)
      $display("FAIL reset_outputs: got gnt=%b done=%b psel=%b paddr=%h, want all 0", gnt_o, done_o, psel_o, paddr_o);
    else passed++;
    prst = 1'b0;
    @(negedge pclk);
    checks++;
    if ({gnt_o, psel_o, penable_o} !== '0)
      $display("FAIL idle_after_reset: got gnt=%b psel=%b penable=%b, want 0", gnt_o, psel_o, penable_o);
    else passed++;
  endtask

  task automatic test_write_read;
    logic [3:0] d; logic [7:0] rd; logic er; int cyc; exp_t e;
    drive_req(1, 8'h03, 8'hA5, 1'b1);
    sb.push_back('{id: 2'd1, rdata: 8'h00, err: 1'b0});
    @(negedge pclk);
    checks++;
    if ({psel_o, penable_o, gnt_o} !== {1'b1, 1'b0, 4'b0010})
      $display("FAIL wr_setup: got psel=%b penable=%b gnt=%b, want 1 0 0010", psel_o, penable_o, gnt_o);
    else passed++;
    checks++;
    if ({pwrite_o, paddr_o, pwdata_o} !== {1'b1, 8'h03, 8'hA5})
      $display("FAIL wr_port: got pwrite=%b paddr=%h pwdata=%h, want 1 03 a5", pwrite_o, paddr_o, pwdata_o);
    else passed++;
    @(negedge pclk);
    checks++;
    if ({psel_o, penable_o} !== 2'b11)
      $display("FAIL wr_access: got psel=%b penable=%b, want 1 1", psel_o, penable_o);
    else passed++;
    wait_done(10, d, rd, er, cyc);
    req_i[1] = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({d, rd, er} !== {4'b0001 << e.id, e.rdata, e.err})
      $display("FAIL wr_done: got done=%b rdata=%h err=%b, want %b %h %b", d, rd, er, 4'b0001 << e.id, e.rdata, e.err);
    else passed++;
    @(negedge pclk);
    checks++;
    if ({done_o, psel_o, gnt_o} !== '0)
      $display("FAIL wr_done_pulse: got done=%b psel=%b gnt=%b, want 0", done_o, psel_o, gnt_o);
    else passed++;
    drive_req(2, 8'h03, 8'h00, 1'b0);
    sb.push_back('{id: 2'd2, rdata: 8'hA5, err: 1'b0});
    wait_done(10, d, rd, er, cyc);
    req_i[2] = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({d, rd, er} !== {4'b0001 << e.id, e.rdata, e.err})
      $display("FAIL rd_done: got done=%b rdata=%h err=%b, want %b %h %b", d, rd, er, 4'b0001 << e.id, e.rdata, e.err);
    else passed++;
    checks++;
    if (cyc != 3) $display("FAIL rd_latency: got %0d cycles, want 3", cyc);
    else passed++;
  endtask

  task automatic test_fairness;
    int ndone = 0, cyc = 0, last = -1, bad_gap = 0, bad_onehot = 0;
    exp_t e;
    prst = 1'b1;
    @(negedge pclk);
    prst = 1'b0;
    for (int r = 0; r < N; r++) drive_req(r, 8'h10 + 8'(r), 8'h00, 1'b0);
    for (int k = 0; k < 8; k++)
      sb.push_back('{id: 2'(k % N), rdata: (8'h10 + 8'(k % N)) ^ 8'h5A, err: 1'b0});
    while (ndone < 8 && cyc < 200) begin
      @(negedge pclk);
      cyc++;
      if (!$onehot0(gnt_o)) bad_onehot++;
      if (done_o != 0) begin
        e = sb.pop_front();
        checks++;
        if (done_o !== (4'b0001 << e.id))
          $display("FAIL rr_order[%0d]: got done=%b, want %b", ndone, done_o, 4'b0001 << e.id);
        else passed++;
        checks++;
        if (rdata_o !== e.rdata)
          $display("FAIL rr_rdata[%0d]: got %h, want %h", ndone, rdata_o, e.rdata);
        else passed++;
        if (last >= 0 && cyc - last != 4) bad_gap++;
        last = cyc;
        ndone++;
        if (ndone == 8) req_i = '0;
      end
    end
    checks++;
    if (ndone != 8) $display("FAIL rr_count: got %0d transfers, want 8", ndone);
    else passed++;
    checks++;
    if (bad_gap != 0) $display("FAIL rr_throughput: got %0d gaps not 4 cycles, want 0", bad_gap);
    else passed++;
    checks++;
    if (bad_onehot != 0) $display("FAIL rr_onehot: got %0d bad gnt cycles, want 0", bad_onehot);
    else passed++;
  endtask

  task automatic test_wait_states;
    int acc = 0, dones = 0, unstable = 0;
    logic [3:0] d = '0; logic er = 1'b0;
    exp_t e;
    drive_req(3, 8'h40, 8'h3C, 1'b1);
    sb.push_back('{id: 2'd3, rdata: 8'h00, err: 1'b0});
    pready_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (psel_o && penable_o) begin
        acc++;
        if (paddr_o !== 8'h40 || pwdata_o !== 8'h3C) unstable++;
        if (acc == 6) pready_i = 1'b1;
      end
      if (done_o != 0) begin
        dones++;
        if (dones == 1) begin d = done_o; er = err_o; req_i[3] = 1'b0; end
      end
    end
    pready_i = 1'b1;
    e = sb.pop_front();
    checks++;
    if (acc != 6) $display("FAIL ws_access_len: got %0d cycles, want 6", acc);
    else passed++;
    checks++;
    if (unstable != 0) $display("FAIL ws_stable: got %0d unstable cycles, want 0", unstable);
    else passed++;
    checks++;
    if (dones != 1) $display("FAIL ws_done_count: got %0d, want 1", dones);
    else passed++;
    checks++;
    if ({d, er} !== {4'b0001 << e.id, e.err})
      $display("FAIL ws_done: got done=%b err=%b, want %b %b", d, er, 4'b0001 << e.id, e.err);
    else passed++;
  endtask

  task automatic test_slave_error;
    logic [3:0] d; logic [7:0] rd; logic er; int cyc; exp_t e;
    drive_req(2, 8'h20, 8'h00, 1'b0);
    sb.push_back('{id: 2'd2, rdata: 8'h7A, err: 1'b1});
    wait_done(10, d, rd, er, cyc);
    req_i[2] = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({d, rd, er} !== {4'b0001 << e.id, e.rdata, e.err})
      $display("FAIL err_done: got done=%b rdata=%h err=%b, want %b %h %b", d, rd, er, 4'b0001 << e.id, e.rdata, e.err);
    else passed++;
    @(negedge pclk);
    checks++;
    if ({err_o, rdata_o} !== '0)
      $display("FAIL err_clear: got err=%b rdata=%h, want 0 00", err_o, rdata_o);
    else passed++;
  endtask

  task automatic test_reset_abort;
    logic [3:0] d; logic [7:0] rd; logic er; int cyc, n = 0, dones = 0; exp_t e;
    drive_req(0, 8'h50, 8'h00, 1'b0);
    pready_i = 1'b0;
    while (!(psel_o && penable_o) && n < 10) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (!(psel_o && penable_o)) $display("FAIL abort_reach_access: got psel=%b penable=%b, want 1 1", psel_o, penable_o);
    else passed++;
    #2 prst = 1'b1;
    #1;
    checks++;
    if ({gnt_o, done_o, rdata_o, err_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== '0)
      $display("FAIL abort_async: got gnt=%b psel=%b penable=%b paddr=%h, want all 0", gnt_o, psel_o, penable_o, paddr_o);
    else passed++;
    repeat (2) begin
      @(negedge pclk);
      if (done_o != 0) dones++;
    end
    drive_req(3, 8'h60, 8'h00, 1'b0);
    pready_i = 1'b1;
    prst = 1'b0;
    sb.push_back('{id: 2'd0, rdata: 8'h0A, err: 1'b0});
    sb.push_back('{id: 2'd3, rdata: 8'h3A, err: 1'b0});
    @(negedge pclk);
    if (done_o != 0) dones++;
    checks++;
    if (dones != 0) $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
    else passed++;
    checks++;
    if (gnt_o !== 4'b0001) $display("FAIL abort_first_winner: got gnt=%b, want 0001", gnt_o);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      wait_done(12, d, rd, er, cyc);
      req_i = req_i & ~d;
      e = sb.pop_front();
      checks++;
      if ({d, rd, er} !== {4'b0001 << e.id, e.rdata, e.err})
        $display("FAIL abort_after[%0d]: got done=%b rdata=%h err=%b, want %b %h %b", k, d, rd, er, 4'b0001 << e.id, e.rdata, e.err);
      else passed++;
    end
    req_i = '0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [3:0] d = '0; logic [7:0] rd = '0; logic er = 1'b0; int acc = 0, cyc = 0; exp_t e;
    drive_req(1, 8'h11, 8'h00, 1'b0);
    drive_req(2, 8'h12, 8'h00, 1'b0);
    pready_i = 1'b0;
    sb.push_back('{id: 2'd1, rdata: 8'h00, err: 1'b1});
    while (cyc < 40) begin
      @(negedge pclk);
      cyc++;
      if (psel_o && penable_o) acc++;
      if (done_o != 0) begin d = done_o; rd = rdata_o; er = err_o; break; end
    end
    req_i[1] = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({d, rd, er} !== {4'b0001 << e.id, e.rdata, e.err})
      $display("FAIL to_done: got done=%b rdata=%h err=%b, want %b %h %b", d, rd, er, 4'b0001 << e.id, e.rdata, e.err);
    else passed++;
    checks++;
    if (acc != 15) $display("FAIL to_access_len: got %0d cycles, want 15", acc);
    else passed++;
    pready_i = 1'b1;
    sb.push_back('{id: 2'd2, rdata: 8'h12 ^ 8'h5A, err: 1'b0});
    repeat (2) @(negedge pclk);
    checks++;
    if (gnt_o !== 4'b0100) $display("FAIL to_next_grant: got gnt=%b, want 0100", gnt_o);
    else passed++;
    wait_done(10, d, rd, er, cyc);
    req_i[2] = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({d, rd, er} !== {4'b0001 << e.id, e.rdata, e.err})
      $display("FAIL to_next_done: got done=%b rdata=%h err=%b, want %b %h %b", d, rd, er, 4'b0001 << e.id, e.rdata, e.err);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_fairness();
    test_wait_states();
    test_slave_error();
    test_reset_abort();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Shares the single 8-bit APB-style register port of the interrupt controller among NUM_REQ requesters, such as the CPU shim, a debug port and a DMA config engine. Requests are granted round-robin. For each granted request the arbiter runs one SETUP/ACCESS transfer on the shared port and returns read data and error status to the winner. Completion is signalled with a single-cycle done pulse.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; range 2..8
- AW, 8, address width
- DW, 8, data width
- TIMEOUT_CYCLES, 15, ACCESS-phase wait limit; used only with ARB_TIMEOUT_EN

Ports:
- pclk_i  in  1  clock; all logic on rising edge
- prst_i  in  1  reset; asynchronous, active-high
- req_i  in  NUM_REQ  per-requester request level
- req_addr_i  in  NUM_REQ*AW  per-requester address; slice r is [r*AW +: AW]
- req_wdata_i  in  NUM_REQ*DW  per-requester write data
- req_write_i  in  NUM_REQ  1 = write, 0 = read
- gnt_o  out  NUM_REQ  one-hot grant; held for the whole transfer
- done_o  out  NUM_REQ  one-cycle completion pulse to the winner
- rdata_o  out  DW  read data; valid only while done_o is high
- err_o  out  1  error flag; valid only while done_o is high
- psel_o  out  1  shared port select
- penable_o  out  1  shared port enable
- pwrite_o  out  1  shared port direction
- paddr_o  out  AW  shared port address
- pwdata_o  out  DW  shared port write data
- pready_i  in  1  slave ready
- prdata_i  in  DW  slave read data
- perror_i  in  1  slave error

## Operation
FSM, one-hot 3-bit encoding: IDLE=001, SETUP=010, ACCESS=100.

- **IDLE**
  - If req_i != 0, pick the winner w by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Latch w's address, write data and direction into paddr_o, pwdata_o and pwrite_o.
  - Set gnt_o[w]=1 and psel_o=1, then go to SETUP.
- **SETUP**
  - Set penable_o=1, then go to ACCESS.
- **ACCESS**
  - On a sampled pready_i=1:
    - clear psel_o, penable_o and gnt_o;
    - pulse done_o[w];
    - capture rdata_o = prdata_i on reads, or 0 on writes;
    - capture err_o = perror_i;
    - set last_grant = w and go to IDLE.

Rules:
- All outputs are registered.
- The requester must hold its req, addr, wdata and write stable from assertion until done.
- The requester must drop req_i in the cycle done_o is high. A req_i still high at the end of that cycle is treated as a new request.
- If req_i is withdrawn mid-transfer, the transfer still completes and done_o still pulses.
- Addresses are not range-checked; slave errors pass through on err_o.
- rdata_o and err_o return to 0 the cycle after done_o.

Reset values:
- All outputs 0 and state IDLE.
- last_grant = NUM_REQ-1, so requester 0 wins first after reset.
- Assertion of prst_i mid-transfer aborts the transfer immediately; no done_o is issued.

## Timing
- Request-to-psel_o: 1 edge.
- SETUP lasts exactly 1 cycle.
- ACCESS lasts at least 1 cycle and extends while pready_i=0.
- With pready_i tied high, done_o is high 3 cycles after req_i is sampled.
- There is one mandatory IDLE cycle between transfers. Back-to-back throughput is one transfer per 4 cycles, or 5 cycles against the interrupt controller's registered pready.
- Fairness: if all requesters assert continuously, grants follow 0,1,2,...,NUM_REQ-1,0.

## Configuration
- **ARB_TIMEOUT_EN defined:**
  - An ACCESS cycle counter clears on ACCESS entry and increments each cycle pready_i=0.
  - If the counter reaches TIMEOUT_CYCLES, the arbiter aborts: psel_o and penable_o drop, done_o[w] pulses, err_o=1, rdata_o=0, last_grant updates, and the FSM returns to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - If pready_i and the timeout coincide, pready_i wins.
- **ARB_TIMEOUT_EN not defined:** ACCESS waits indefinitely and TIMEOUT_CYCLES is unused.

## Structure
- Shared package arb_pkg contains:
  - the state encoding constants;
  - the default AW and DW;
  - a grant index-to-one-hot function.
- One sub-module, arb_rr_pick: combinational round-robin picker.
  - Inputs: req vector and last_grant.
  - Outputs: winner index and a valid flag.

## Test plan
- Reset, then requester 1 writes addr 0x03 data 0xA5:
  - psel_o is high 1 edge later and penable_o the next edge.
  - done_o[1] pulses with err_o=0.
  - A follow-up read of 0x03 by requester 2 returns rdata_o=0xA5.
- All 4 requesters held high for 8 transfers → grant order 0,1,2,3,0,1,2,3; gnt_o is one-hot at all times.
- Slave holds pready_i low for 5 cycles → ACCESS lasts 6 cycles; paddr_o and pwdata_o stay stable; done_o fires once.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=15, pready_i stuck at 0 → done_o pulses after 15 ACCESS cycles with err_o=1 and rdata_o=0; the next requester is then granted.
- prst_i asserted during ACCESS → all outputs 0 asynchronously and no done_o; after release with requesters 0 and 3 active, requester 0 wins.
- Slave returns perror_i=1 on addr 0x20 → done_o pulses with err_o=1; err_o returns to 0 the following cycle.
